// File: rtl/csr_wb_master.sv
// CSR-programmed Wishbone initiator. Software loads address, data, byte
// selects and direction through a small CSR page, then kicks off one
// classic single Wishbone cycle. A programmable timeout rescues the bus
// from slaves that never acknowledge.
module csr_wb_master #(
    parameter logic [3:0]  csr_addr    = 4'h4,
    parameter logic [31:0] TIMEOUT_RST = 32'd1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic [2:0]  wb_cti_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t      state, state_nxt;
    logic [31:0] adr_r, wdat_r, rdat_r, timeout_r, tmo_cnt;
    logic [3:0]  sel_r;
    logic        we_r, done_r, tmo_r;
    logic        page_sel, csr_wr, start, bus_ack, bus_tmo, bus_end;
    logic [2:0]  reg_idx;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    assign page_sel = (csr_a[13:10] == csr_addr);
    assign csr_wr   = csr_we & page_sel;
    assign reg_idx  = csr_a[2:0];
    // A start while a cycle is in flight is dropped entirely.
    assign start    = csr_wr && (reg_idx == 3'd3) && csr_di[0] && (state == IDLE);
    assign bus_end  = bus_ack | bus_tmo;

    assign unused_addr_bits = ^csr_a[9:3];

    // Bus outputs come straight from state so reset drops cyc/stb asynchronously.
    assign wb_cyc_o = (state == BUS);
    assign wb_stb_o = (state == BUS);
    assign wb_adr_o = adr_r;
    assign wb_dat_o = wdat_r;
    assign wb_sel_o = sel_r;
    assign wb_we_o  = we_r;
    assign wb_cti_o = 3'b000;

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next state; ack takes priority over an expiring timeout.
    always_comb begin
        state_nxt = state;
        bus_ack   = 1'b0;
        bus_tmo   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = BUS;
            BUS: begin
                if (wb_ack_i) begin
                    bus_ack   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == 32'd1) begin
                    bus_tmo   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // CSR-writable registers; bus-facing ones are frozen while a cycle runs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            adr_r     <= 32'd0;
            wdat_r    <= 32'd0;
            sel_r     <= 4'hf;
            we_r      <= 1'b0;
            timeout_r <= TIMEOUT_RST;
        end else if (csr_wr) begin
            case (reg_idx)
                3'd0: if (state == IDLE) adr_r  <= csr_di;
                3'd1: if (state == IDLE) wdat_r <= csr_di;
                3'd3: if (state == IDLE) begin
                    we_r  <= csr_di[1];
                    sel_r <= csr_di[7:4];
                end
                3'd5: timeout_r <= csr_di;
                default: ;
            endcase
        end
    end

    // Timeout counter: loads on start, counts down each un-acked bus cycle; 0 never expires.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)                                          tmo_cnt <= 32'd0;
        else if (start)                                          tmo_cnt <= timeout_r;
        else if (state == BUS && !wb_ack_i && tmo_cnt != 32'd0) tmo_cnt <= tmo_cnt - 32'd1;
    end

    // Read data capture and completion flags; a set beats a same-cycle clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rdat_r <= 32'd0;
            done_r <= 1'b0;
            tmo_r  <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq <= bus_end;
            if (bus_ack && !we_r) rdat_r <= wb_dat_i;

            if (start)                                              done_r <= 1'b0;
            else if (bus_end)                                       done_r <= 1'b1;
            else if (csr_wr && reg_idx == 3'd4 && csr_di[1])        done_r <= 1'b0;

            if (start)                                              tmo_r <= 1'b0;
            else if (bus_tmo)                                       tmo_r <= 1'b1;
            else if (csr_wr && reg_idx == 3'd4 && csr_di[2])        tmo_r <= 1'b0;
        end
    end

    // Read mux for the selected register.
    always_comb begin
        rd_mux = 32'd0;
        case (reg_idx)
            3'd0: rd_mux = adr_r;
            3'd1: rd_mux = wdat_r;
            3'd2: rd_mux = rdat_r;
            3'd3: rd_mux = {24'd0, sel_r, 2'b00, we_r, 1'b0};
            3'd4: rd_mux = {29'd0, tmo_r, done_r, (state == BUS)};
            3'd5: rd_mux = timeout_r;
            default: rd_mux = 32'd0;
        endcase
    end

    // Registered read data, zero outside our page so the bus can OR slaves.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)    csr_do <= 32'd0;
        else if (page_sel) csr_do <= rd_mux;
        else               csr_do <= 32'd0;
    end

endmodule

// File: tb/tb_csr_wb_master.sv
// Directed bench for csr_wb_master with a simple wait-state slave model.
module tb_csr_wb_master;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di;
    logic [31:0] csr_do;
    logic        irq;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [2:0]  wb_cti_o;
    logic        wb_cyc_o, wb_stb_o, wb_ack_i;

    int errors = 0;
    int checks = 0;

    // Slave model knobs.
    int          slv_wait  = 0;
    logic        slv_never = 1'b0;
    logic [31:0] slv_data  = 32'd0;
    int          wcnt      = 0;

    // Bus monitor.
    int          cyc_cnt = 0, txn_cnt = 0, irq_cnt = 0;
    logic        prev_cyc = 1'b0;
    logic [31:0] last_adr = 32'd0, last_dat = 32'd0;
    logic [3:0]  last_sel = 4'd0;
    logic        last_we  = 1'b0;

    always #5 sys_clk = ~sys_clk;

    csr_wb_master dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .irq       (irq),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_o  (wb_sel_o),
        .wb_we_o   (wb_we_o),
        .wb_cti_o  (wb_cti_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_ack_i  (wb_ack_i)
    );

    assign wb_ack_i = wb_cyc_o && wb_stb_o && !slv_never && (wcnt >= slv_wait);
    assign wb_dat_i = slv_data;

    always @(posedge sys_clk) begin
        wcnt <= wb_cyc_o ? wcnt + 1 : 0;
        if (wb_cyc_o) begin
            cyc_cnt  <= cyc_cnt + 1;
            last_adr <= wb_adr_o;
            last_dat <= wb_dat_o;
            last_sel <= wb_sel_o;
            last_we  <= wb_we_o;
        end
        if (wb_cyc_o && !prev_cyc) txn_cnt <= txn_cnt + 1;
        prev_cyc <= wb_cyc_o;
        if (irq) irq_cnt <= irq_cnt + 1;
    end

    function automatic logic [13:0] pg(input logic [3:0] page, input logic [2:0] idx);
        return {page, 7'd0, idx};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [13:0] a, output logic [31:0] d);
        @(negedge sys_clk);
        csr_a  = a;
        csr_we = 1'b0;
        @(negedge sys_clk);
        d = csr_do;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        csr_rd(pg(4'h4, idx), d);
        chk(tag, d, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (wb_cyc_o && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, {31'd0, wb_cyc_o}, 32'd0);
        repeat (3) @(negedge sys_clk);
    endtask

    initial begin
        int c0, t0, i0;
        logic [31:0] d;
        sys_rst_n = 1'b0;
        csr_a = 14'd0; csr_we = 1'b0; csr_di = 32'd0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_csr_do", csr_do, 32'd0);
        chk("rst_cti", {29'd0, wb_cti_o}, 32'd0);
        sys_rst_n = 1'b1;
        rd_chk("rst_addr", 3'd0, 32'd0);
        rd_chk("rst_ctrl", 3'd3, 32'h0000_00F0);
        rd_chk("rst_status", 3'd4, 32'd0);
        rd_chk("rst_timeout", 3'd5, 32'd1024);
        rd_chk("rd_idx6", 3'd6, 32'd0);

        // Write with combinational-ack slave
        slv_wait = 0; slv_never = 1'b0;
        c0 = cyc_cnt; t0 = txn_cnt; i0 = irq_cnt;
        csr_wr(pg(4'h4, 3'd0), 32'h3000_0010);
        csr_wr(pg(4'h4, 3'd1), 32'hA5A5_5A5A);
        csr_wr(pg(4'h4, 3'd3), 32'h0000_00F3);
        wait_idle("wr_done_bound");
        chk("wr_cyc_len", cyc_cnt - c0, 1);
        chk("wr_txns", txn_cnt - t0, 1);
        chk("wr_irq", irq_cnt - i0, 1);
        chk("wr_adr", last_adr, 32'h3000_0010);
        chk("wr_dat", last_dat, 32'hA5A5_5A5A);
        chk("wr_sel", {28'd0, last_sel}, 32'hf);
        chk("wr_we", {31'd0, last_we}, 32'd1);
        rd_chk("wr_status", 3'd4, 32'h2);

        // Read with 3 wait states
        slv_wait = 3; slv_data = 32'hDEAD_BEEF;
        c0 = cyc_cnt; t0 = txn_cnt; i0 = irq_cnt;
        csr_wr(pg(4'h4, 3'd3), 32'h0000_0031);
        wait_idle("rd_done_bound");
        chk("rd_cyc_len", cyc_cnt - c0, 4);
        chk("rd_irq", irq_cnt - i0, 1);
        chk("rd_sel", {28'd0, last_sel}, 32'h3);
        chk("rd_we", {31'd0, last_we}, 32'd0);
        rd_chk("rd_rdata", 3'd2, 32'hDEAD_BEEF);
        rd_chk("rd_status", 3'd4, 32'h2);

        // Timeout against a dead slave
        slv_never = 1'b1;
        csr_wr(pg(4'h4, 3'd5), 32'd5);
        c0 = cyc_cnt; i0 = irq_cnt;
        csr_wr(pg(4'h4, 3'd3), 32'h0000_0001);
        wait_idle("tmo_done_bound");
        chk("tmo_cyc_len", cyc_cnt - c0, 5);
        chk("tmo_irq", irq_cnt - i0, 1);
        rd_chk("tmo_status", 3'd4, 32'h6);
        rd_chk("tmo_rdata", 3'd2, 32'hDEAD_BEEF);
        csr_wr(pg(4'h4, 3'd4), 32'h6);
        rd_chk("tmo_clear", 3'd4, 32'h0);

        // Start and address write while busy are ignored; timeout disabled
        slv_never = 1'b0; slv_wait = 6; slv_data = 32'h1234_5678;
        csr_wr(pg(4'h4, 3'd5), 32'd0);
        csr_wr(pg(4'h4, 3'd0), 32'h0000_0040);
        c0 = cyc_cnt; t0 = txn_cnt;
        csr_wr(pg(4'h4, 3'd3), 32'h0000_0031);
        csr_wr(pg(4'h4, 3'd3), 32'h0000_0003);
        csr_wr(pg(4'h4, 3'd0), 32'h0000_0000);
        rd_chk("busy_status", 3'd4, 32'h1);
        wait_idle("busy_done_bound");
        repeat (4) @(negedge sys_clk);
        chk("busy_txns", txn_cnt - t0, 1);
        chk("busy_cyc_len", cyc_cnt - c0, 7);
        chk("busy_adr", last_adr, 32'h0000_0040);
        chk("busy_we", {31'd0, last_we}, 32'd0);
        rd_chk("busy_addr_reg", 3'd0, 32'h0000_0040);
        rd_chk("busy_ctrl_reg", 3'd3, 32'h0000_0030);
        rd_chk("busy_rdata", 3'd2, 32'h1234_5678);

        // Asynchronous reset during a stalled cycle
        slv_never = 1'b1;
        csr_wr(pg(4'h4, 3'd1), 32'h0000_0077);
        csr_wr(pg(4'h4, 3'd3), 32'h0000_0001);
        @(negedge sys_clk);
        chk("arst_pre_cyc", {31'd0, wb_cyc_o}, 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("arst_stb", {31'd0, wb_stb_o}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        slv_never = 1'b0; slv_wait = 0;
        rd_chk("arst_addr", 3'd0, 32'd0);
        rd_chk("arst_wdata", 3'd1, 32'd0);
        rd_chk("arst_rdata", 3'd2, 32'd0);
        rd_chk("arst_ctrl", 3'd3, 32'h0000_00F0);
        rd_chk("arst_status", 3'd4, 32'd0);
        rd_chk("arst_timeout", 3'd5, 32'd1024);

        // Page decode
        csr_wr(pg(4'h4, 3'd0), 32'h0000_0011);
        csr_rd(pg(4'h3, 3'd0), d);
        chk("page_rd_zero", d, 32'd0);
        csr_wr(pg(4'h3, 3'd0), 32'h0000_0099);
        rd_chk("page_wr_ignored", 3'd0, 32'h0000_0011);

        // Ack and timeout expire in the same cycle
        csr_wr(pg(4'h4, 3'd5), 32'd1);
        csr_wr(pg(4'h4, 3'd3), 32'h0000_0001);
        wait_idle("race_done_bound");
        rd_chk("race_status", 3'd4, 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
